telemetry_packetizer: RTL and testbench

Periodic multi-channel telemetry framer for the acoustic turret. On each period tick, or on a forced send, it snapshots the current turret angle and NUM_CH microphone samples. It serialises them into a framed, checksummed byte packet and feeds them one byte at a time to the UART transmitter using its data_rdy/tx_busy handshake. It supersedes the top-level one-byte-per-second angle sender.

---
 rtl/telemetry_pkg.sv | 22 ++
 rtl/telemetry_packetizer_if.sv | 9 +
 rtl/period_ticker.sv | 29 ++
 rtl/telemetry_packetizer.sv | 123 ++++++++++++
 tb/tb_telemetry_packetizer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/telemetry_pkg.sv
// Shared types and sizing helpers for the telemetry packetizer.
package telemetry_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   function automatic int bytes_per_ch(input int data_w);
      return (data_w + 7) / 8;
   endfunction

   function automatic int pkt_len(input int num_ch, input int data_w);
      return 4 + num_ch * bytes_per_ch(data_w);
   endfunction

endpackage

// File: rtl/telemetry_packetizer_if.sv
// Byte handshake towards the UART: tx_start launches tx_data, tx_busy reports transmission.
interface telemetry_packetizer_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;

   modport master (output tx_data, output tx_start, input tx_busy);
   modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/period_ticker.sv
// Free-running period counter; tick is combinational in the cycle the count hits PERIOD_CYCLES-1.
// Holds at zero while enable is low, so ticks restart a full period after enable rises.
module period_ticker #(
   parameter int PERIOD_CYCLES = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);
   localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!enable) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign tick = enable && (r_cnt == LAST_CNT);
endmodule

// File: rtl/telemetry_packetizer.sv
// Snapshots angle and channel samples on a trigger and streams a checksummed packet, one byte per UART handshake.
// Each byte waits for tx_busy low before launch; triggers arriving mid-packet are dropped and counted.
module telemetry_packetizer
   import telemetry_pkg::*;
#(
   parameter int         NUM_CH        = 2,
   parameter int         DATA_W        = 18,
   parameter int         PERIOD_CYCLES = 100_000_000,
   parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     force_send,
   input  logic [7:0]               angle,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   telemetry_packetizer_if.master   tx,
   output logic                     pkt_active,
   output logic [7:0]               seq,
   output logic [7:0]               overrun_cnt
);
   localparam int BPC     = bytes_per_ch(DATA_W);
   localparam int PKT_LEN = pkt_len(NUM_CH, DATA_W);
   localparam int IDX_W   = $clog2(PKT_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

   state_t                  r_state, w_state_nxt;
   logic                    w_tick, w_trigger, w_start_nxt;
   logic [IDX_W-1:0]        r_idx;
   logic [7:0]              r_cks, r_seq, r_ovr, r_angle, r_tx_data;
   logic [NUM_CH*DATA_W-1:0] r_ch;
   logic                    r_active, r_tx_start;
   logic [7:0]              w_byte;
   logic [BPC*8-1:0]        w_ext;

   period_ticker #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_ticker (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .tick   (w_tick)
   );

   assign w_trigger = w_tick | force_send;

   // Byte select: header, sign-extended channel bytes MSB first, then the running checksum.
   always_comb begin
      w_byte = 8'h00;
      w_ext  = '0;
      if (r_idx == IDX_W'(0))      w_byte = SYNC_BYTE;
      else if (r_idx == IDX_W'(1)) w_byte = r_seq;
      else if (r_idx == IDX_W'(2)) w_byte = r_angle;
      else if (r_idx == LAST_IDX)  w_byte = r_cks;
      for (int k = 0; k < NUM_CH; k++) begin
         w_ext = {(BPC*8){r_ch[k*DATA_W + DATA_W - 1]}};
         w_ext[DATA_W-1:0] = r_ch[k*DATA_W +: DATA_W];
         for (int b = 0; b < BPC; b++) begin
            if (r_idx == IDX_W'(3 + k*BPC + b)) w_byte = w_ext[(BPC-1-b)*8 +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = 1'b0;
      case (r_state)
         S_IDLE:      if (w_trigger) w_state_nxt = S_LOAD;
         S_LOAD:      w_state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (!tx.tx_busy) begin
               w_start_nxt = 1'b1;
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK:  if (tx.tx_busy) w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (!tx.tx_busy) w_state_nxt = (r_idx == LAST_IDX) ? S_IDLE : S_LOAD;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
         r_idx      <= '0;
         r_cks      <= 8'h00;
         r_seq      <= 8'h00;
         r_ovr      <= 8'h00;
         r_angle    <= 8'h00;
         r_ch       <= '0;
         r_active   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_start <= w_start_nxt;
         if (r_state == S_IDLE && w_trigger) begin
            r_angle  <= angle;
            r_ch     <= ch_data;
            r_idx    <= '0;
            r_cks    <= 8'h00;
            r_active <= 1'b1;
         end
         if (w_trigger && r_active && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
         if (r_state == S_LOAD) r_tx_data <= w_byte;
         // Sync and checksum bytes themselves are excluded from the sum.
         if (r_state == S_ISSUE && !tx.tx_busy && r_idx != IDX_W'(0) && r_idx != LAST_IDX)
            r_cks <= r_cks + r_tx_data;
         if (r_state == S_WAIT_DONE && !tx.tx_busy) begin
            if (r_idx == LAST_IDX) begin
               r_active <= 1'b0;
               r_seq    <= r_seq + 8'd1;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
      end
   end

   assign tx.tx_data   = r_tx_data;
   assign tx.tx_start  = r_tx_start;
   assign pkt_active   = r_active;
   assign seq          = r_seq;
   assign overrun_cnt  = r_ovr;
endmodule

// File: tb/tb_telemetry_packetizer.sv
// Directed bench: UART model with 10-cycle busy, packet byte checks against hand tables and a small packet builder.
module tb_telemetry_packetizer;
   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        force_send;
   logic [7:0]  angle;
   logic [35:0] ch_data;
   logic        pkt_active;
   logic [7:0]  seq;
   logic [7:0]  overrun_cnt;

   telemetry_packetizer_if tx_if();

   telemetry_packetizer #(
      .NUM_CH(2), .DATA_W(18), .PERIOD_CYCLES(200), .SYNC_BYTE(8'hA5)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .force_send  (force_send),
      .angle       (angle),
      .ch_data     (ch_data),
      .tx          (tx_if),
      .pkt_active  (pkt_active),
      .seq         (seq),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // UART model: busy rises one cycle after a tx_start is seen and stays high for 10 cycles.
   logic       force_busy = 1'b0;
   int         busy_cnt = 0;
   bit         pend = 1'b0;
   int         n_start = 0;
   logic [7:0] q_bytes[$];

   always @(negedge clock) begin
      if (tx_if.tx_start) n_start++;
      if (reset) begin
         tx_if.tx_busy = 1'b0;
         pend = 1'b0;
         busy_cnt = 0;
      end else begin
         if (tx_if.tx_start) q_bytes.push_back(tx_if.tx_data);
         if (pend) begin
            pend = 1'b0;
            busy_cnt = 10;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         if (tx_if.tx_start) pend = 1'b1;
         tx_if.tx_busy = force_busy || (busy_cnt > 0);
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic pulse_force();
      force_send = 1'b1;
      step();
      force_send = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (pkt_active && n < budget) begin
         step();
         n++;
      end
      check({tag, " idle"}, 32'(pkt_active), 32'd0);
   endtask

   task automatic check_pkt(input string tag, input logic [7:0] s, input logic [7:0] a,
                            input logic [35:0] ch);
      logic [7:0]  b[10];
      logic [23:0] e0, e1;
      logic [7:0]  cks;
      logic [7:0]  got;
      e0 = {{6{ch[17]}}, ch[17:0]};
      e1 = {{6{ch[35]}}, ch[35:18]};
      b[0] = 8'hA5; b[1] = s; b[2] = a;
      b[3] = e0[23:16]; b[4] = e0[15:8]; b[5] = e0[7:0];
      b[6] = e1[23:16]; b[7] = e1[15:8]; b[8] = e1[7:0];
      cks = 8'h00;
      for (int i = 1; i < 9; i++) cks = cks + b[i];
      b[9] = cks;
      for (int i = 0; i < 10; i++) begin
         got = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'hxx;
         check($sformatf("%s byte%0d", tag, i), 32'(got), 32'(b[i]));
      end
   endtask

   logic [7:0] golden[10];
   int n0, n1, guard;

   initial begin
      golden = '{8'hA5, 8'h00, 8'h5A, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h9F};
      reset = 1'b1; enable = 1'b0; force_send = 1'b0; angle = 8'd0; ch_data = '0;
      repeat (3) step();
      check("rst tx_data", 32'(tx_if.tx_data), 32'd0);
      check("rst tx_start", 32'(tx_if.tx_start), 32'd0);
      check("rst pkt_active", 32'(pkt_active), 32'd0);
      check("rst seq", 32'(seq), 32'd0);
      check("rst overrun", 32'(overrun_cnt), 32'd0);
      reset = 1'b0;
      step();

      // Single packet, an overrun 3 cycles later, and inputs changed mid-packet.
      angle = 8'd90; ch_data = {18'h01234, 18'h20001};
      q_bytes.delete();
      pulse_force();
      check("p1 active", 32'(pkt_active), 32'd1);
      step(); step();
      pulse_force();
      angle = 8'd17; ch_data = 36'hF_FFFF_FFFF;
      wait_idle("p1", 1000);
      check("p1 len", 32'(q_bytes.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         logic [7:0] got;
         got = (q_bytes.size() > 0) ? q_bytes.pop_front() : 8'hxx;
         check($sformatf("p1 byte%0d", i), 32'(got), 32'(golden[i]));
      end
      check("p1 seq", 32'(seq), 32'd1);
      check("p1 overrun", 32'(overrun_cnt), 32'd1);

      // Back-pressure: busy held 500 cycles, no launch until it falls.
      angle = 8'd45; ch_data = {18'h3FFFF, 18'h1FFFF};
      force_busy = 1'b1;
      step();
      q_bytes.delete();
      n0 = n_start;
      pulse_force();
      repeat (500) step();
      check("bp no start", 32'(n_start - n0), 32'd0);
      check("bp active", 32'(pkt_active), 32'd1);
      force_busy = 1'b0;
      wait_idle("bp", 1000);
      check_pkt("bp", 8'd1, 8'd45, {18'h3FFFF, 18'h1FFFF});

      // Periodic ticks: 1010 enabled cycles at period 200 give five packets.
      angle = 8'd120; ch_data = {18'h00080, 18'h3FF00};
      q_bytes.delete();
      enable = 1'b1;
      repeat (1010) step();
      enable = 1'b0;
      wait_idle("tick", 1000);
      check("tick len", 32'(q_bytes.size()), 32'd50);
      for (int p = 0; p < 5; p++)
         check_pkt($sformatf("tick%0d", p), 8'(2 + p), 8'd120, {18'h00080, 18'h3FF00});
      check("tick overrun", 32'(overrun_cnt), 32'd1);

      // force_send coincident with a tick counts as one trigger.
      q_bytes.delete();
      enable = 1'b1;
      repeat (199) step();
      force_send = 1'b1;
      step();
      force_send = 1'b0;
      enable = 1'b0;
      wait_idle("simul", 1000);
      check("simul len", 32'(q_bytes.size()), 32'd10);
      check_pkt("simul", 8'd7, 8'd120, {18'h00080, 18'h3FF00});
      check("simul overrun", 32'(overrun_cnt), 32'd1);

      // 300 dropped triggers saturate the overrun counter.
      force_busy = 1'b1;
      step();
      q_bytes.delete();
      pulse_force();
      for (int i = 0; i < 300; i++) pulse_force();
      check("ovr sat", 32'(overrun_cnt), 32'd255);
      force_busy = 1'b0;
      wait_idle("ovr", 1000);
      check_pkt("ovr", 8'd8, 8'd120, {18'h00080, 18'h3FF00});

      // Sequence wrap back to 00.
      angle = 8'd180; ch_data = {18'h2AAAA, 18'h15555};
      for (int p = 9; p < 256; p++) begin
         q_bytes.delete();
         pulse_force();
         wait_idle("wrap", 1000);
         check_pkt($sformatf("wrap%0d", p), 8'(p), 8'd180, {18'h2AAAA, 18'h15555});
      end
      check("wrap seq", 32'(seq), 32'd0);

      // Reset after the fourth byte launches aborts the packet.
      q_bytes.delete();
      n0 = n_start;
      pulse_force();
      guard = 0;
      while ((n_start - n0) < 4 && guard < 500) begin
         step();
         guard++;
      end
      check("mid bytes", 32'(n_start - n0), 32'd4);
      reset = 1'b1;
      n1 = n_start;
      repeat (3) step();
      check("mid tx_start", 32'(tx_if.tx_start), 32'd0);
      check("mid tx_data", 32'(tx_if.tx_data), 32'd0);
      check("mid pkt_active", 32'(pkt_active), 32'd0);
      check("mid seq", 32'(seq), 32'd0);
      check("mid overrun", 32'(overrun_cnt), 32'd0);
      reset = 1'b0;
      repeat (100) step();
      check("mid no start", 32'(n_start - n1), 32'd0);
      q_bytes.delete();
      pulse_force();
      wait_idle("post", 1000);
      check("post len", 32'(q_bytes.size()), 32'd10);
      check_pkt("post", 8'd0, 8'd180, {18'h2AAAA, 18'h15555});
      check("post seq", 32'(seq), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
